aquila_dbus_router: RTL
=======================

Name: aquila_dbus_router

Overview:
- Parametrised data-port router between the Aquila core data port and N memory-mapped slaves (TCM, D-cache, device bus, system devices, ...).
- Replaces the fixed 4-way, segment-nibble address decode and registered response mux with a programmable base/mask region table and an explicit request/response state machine.
- Unmapped accesses get a bus-error response instead of hanging.
- Sits between core_top and the slave ports inside the SoC top.

Parameters:
- XLEN, 32, data/address width.
- N_SLAVES, 4, number of slave regions (1..8).
- REGION_BASE, {32'hF000_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000}, packed N_SLAVES*XLEN bases; slave i uses [i*XLEN +: XLEN].
- REGION_MASK, {32'hF000_0000, 32'hF000_0000, 32'hC000_0000, 32'hF000_0000}, packed address masks.
- REGION_EXT, 4'b1110, bit i set = region i is external/uncached (non-interruptible).
- TIMEOUT_CYCLES, 1024, WAIT-cycle limit (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- p_strobe_i  in  1  core request strobe (one-cycle pulse)
- p_addr_i  in  XLEN  request address
- p_rw_i  in  1  1 = write
- p_byte_enable_i  in  XLEN/8  byte enables
- p_data_i  in  XLEN  write data
- p_data_o  out  XLEN  read data to core
- p_ready_o  out  1  response strobe to core
- p_error_o  out  1  bus error, valid with p_ready_o
- p_addr_ext_o  out  1  decoded region of p_addr_i is external
- busy_o  out  1  transaction outstanding
- s_strobe_o  out  N_SLAVES  one-hot slave strobes
- s_addr_o  out  XLEN  shared address
- s_rw_o  out  N_SLAVES  per-slave write qualifier
- s_byte_enable_o  out  XLEN/8  shared byte enables
- s_data_o  out  XLEN  shared write data
- s_data_i  in  N_SLAVES*XLEN  packed slave read data
- s_ready_i  in  N_SLAVES  slave done strobes

Behaviour:
- Decode (combinational):
  - hit[i] = ((p_addr_i & MASK[i]) == BASE[i]).
  - The lowest matching index wins; no match is a miss.
  - p_addr_ext_o = REGION_EXT[winner], or 1 on a miss.
- States:
  - IDLE: busy_o=0.
  - WAIT: busy_o=1, sel_r valid.
  - ERR: busy_o=1.
- IDLE with p_strobe_i:
  - On a hit, s_strobe_o[winner]=1 and s_rw_o[winner]=p_rw_i in the same cycle.
  - Shared address, byte enables and write data are passed through combinationally; s_addr_o and s_data_o are 0 when not strobing.
  - sel_r <= winner, go to WAIT.
  - On a miss, strobe no slave and go to ERR.
- WAIT:
  - When s_ready_i[sel_r]=1, drive p_ready_o=1 and p_data_o=s_data_i[sel_r] in that cycle, p_error_o=0, then go to IDLE.
  - s_ready_i from non-selected slaves is ignored.
- ERR: one cycle with p_ready_o=1, p_error_o=1, p_data_o=0, then go to IDLE. A miss therefore has fixed 1-cycle latency.
- Latency: a hit is at least 1 cycle after the strobe. s_ready_i in the strobe cycle (IDLE) is ignored.
- p_strobe_i while busy_o=1 is a protocol violation: ignored, no slave strobe.
- Outside a response cycle, p_ready_o=0, p_error_o=0, p_data_o=0.
- Reset (any time, including mid-WAIT): state IDLE, sel_r=0; all outputs 0 (p_addr_ext_o follows the decode). A late s_ready_i after reset is ignored.

Optional Feature:
- Macro: AQUILA_DBUS_TIMEOUT_EN.
- Enabled:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - At TIMEOUT_CYCLES without s_ready_i, the block responds p_ready_o=1, p_error_o=1, p_data_o=0 and returns to IDLE.
  - stale_r[sel_r] is set. The next s_ready_i from a stale slave clears its bit and is discarded.
  - A new request to a stale slave gets an ERR response (no strobe).
  - Reset clears stale_r.
- Disabled: WAIT is unbounded; no counter or stale logic.

Decomposition:
- Package aquila_dbus_pkg holds:
  - state encoding (IDLE/WAIT/ERR);
  - default region constants;
  - the function onehot_to_index.
- Sub-module aquila_region_decoder: combinational base/mask priority decode producing hit, winner index and ext flag. The router holds the FSM, sel_r, response mux and timeout logic.

Test Plan:
- Read to 0x8000_0010 (slave 1), s_ready_i[1] 3 cycles later with data 0xDEAD_BEEF -> s_strobe_o=4'b0010 in the strobe cycle; p_ready_o=1 and p_data_o=0xDEAD_BEEF exactly in the ready cycle; p_addr_ext_o=1.
- Write 0x1234_5678, be=4'b0011 to 0x0000_0040 -> s_strobe_o=4'b0001, s_rw_o=4'b0001, s_data_o=0x1234_5678, s_byte_enable_o=4'b0011; p_addr_ext_o=0.
- Access 0x4000_0000 (unmapped) -> no s_strobe_o; next cycle p_ready_o=1, p_error_o=1, p_data_o=0.
- In WAIT on slave 2, pulse s_ready_i[3] with 0xAAAA_AAAA, then s_ready_i[2] with 0x5555_5555 -> only the second completes; p_data_o=0x5555_5555.
- Assert rst_i mid-WAIT, then pulse s_ready_i[1] after release -> no p_ready_o; busy_o=0.
- With AQUILA_DBUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, a slave never responds -> p_ready_o=1 and p_error_o=1 after 8 WAIT cycles. A new access to the same slave -> error, no strobe. A late s_ready_i is discarded, and the following access succeeds.

Source files
------------

// File: rtl/aquila_dbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aquila_dbus_pkg
//  Description : Shared types, default region table and helpers for the
//                Aquila data-port router.
//  Revision    : 1.0 - initial release
// ============================================================================
package aquila_dbus_pkg;

    // Upper bound on the number of slave regions; the selected index is
    // carried in SEL_W bits regardless of the actual N_SLAVES.
    localparam int MAX_SLAVES = 8;
    localparam int SEL_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } dbus_state_t;

    // Default SoC map: 0 = TCM (0x0xxx_xxxx), 1 = D-cache (0x8..0xB),
    // 2 = device bus (0xCxxx_xxxx), 3 = system devices (0xFxxx_xxxx).
    localparam logic [4*32-1:0] DEF_REGION_BASE =
        {32'hF000_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000};
    localparam logic [4*32-1:0] DEF_REGION_MASK =
        {32'hF000_0000, 32'hF000_0000, 32'hC000_0000, 32'hF000_0000};
    localparam logic [3:0]      DEF_REGION_EXT  = 4'b1110;

    // Encode a one-hot (or all-zero) vector into a binary index.
    function automatic logic [SEL_W-1:0] onehot_to_index(input logic [MAX_SLAVES-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_SLAVES; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aquila_region_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : aquila_region_decoder
//  Description : Combinational base/mask region decode with lowest-index
//                priority. A miss reports ext=1 (treated as uncached).
//  Revision    : 1.0 - initial release
// ============================================================================
module aquila_region_decoder
    import aquila_dbus_pkg::*;
#(
    parameter int                           XLEN        = 32,
    parameter int                           N_SLAVES    = 4,
    parameter logic [N_SLAVES*XLEN-1:0]     REGION_BASE = DEF_REGION_BASE,
    parameter logic [N_SLAVES*XLEN-1:0]     REGION_MASK = DEF_REGION_MASK,
    parameter logic [N_SLAVES-1:0]          REGION_EXT  = DEF_REGION_EXT
) (
    input  logic [XLEN-1:0]     addr_i,
    output logic                hit_o,
    output logic [N_SLAVES-1:0] onehot_o,
    output logic [SEL_W-1:0]    index_o,
    output logic                ext_o
);

    logic [N_SLAVES-1:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLAVES; gi++) begin : g_region
            assign w_hit[gi] = ((addr_i & REGION_MASK[gi*XLEN +: XLEN])
                                == REGION_BASE[gi*XLEN +: XLEN]);
        end
    endgenerate

    // Keep only the lowest-index hit so overlapping regions resolve deterministically.
    always_comb begin
        logic w_found;
        w_found  = 1'b0;
        onehot_o = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (w_hit[i] && !w_found) begin
                onehot_o[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    assign hit_o   = |w_hit;
    assign index_o = onehot_to_index(MAX_SLAVES'(onehot_o));
    assign ext_o   = hit_o ? |(onehot_o & REGION_EXT) : 1'b1;

endmodule
`default_nettype wire

// File: rtl/aquila_dbus_router.sv
`default_nettype none
// ============================================================================
//  Module      : aquila_dbus_router
//  Description : Aquila core data-port router to N memory-mapped slaves.
//                Programmable base/mask decode, IDLE/WAIT/ERR handshake FSM,
//                bus-error response for unmapped addresses.
//                Optional macro AQUILA_DBUS_TIMEOUT_EN adds a WAIT timeout
//                with per-slave stale tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module aquila_dbus_router
    import aquila_dbus_pkg::*;
#(
    parameter int                           XLEN           = 32,
    parameter int                           N_SLAVES       = 4,
    parameter logic [N_SLAVES*XLEN-1:0]     REGION_BASE    = DEF_REGION_BASE,
    parameter logic [N_SLAVES*XLEN-1:0]     REGION_MASK    = DEF_REGION_MASK,
    parameter logic [N_SLAVES-1:0]          REGION_EXT     = DEF_REGION_EXT,
    parameter int                           TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     p_strobe_i,
    input  logic [XLEN-1:0]          p_addr_i,
    input  logic                     p_rw_i,
    input  logic [XLEN/8-1:0]        p_byte_enable_i,
    input  logic [XLEN-1:0]          p_data_i,
    output logic [XLEN-1:0]          p_data_o,
    output logic                     p_ready_o,
    output logic                     p_error_o,
    output logic                     p_addr_ext_o,
    output logic                     busy_o,
    output logic [N_SLAVES-1:0]      s_strobe_o,
    output logic [XLEN-1:0]          s_addr_o,
    output logic [N_SLAVES-1:0]      s_rw_o,
    output logic [XLEN/8-1:0]        s_byte_enable_o,
    output logic [XLEN-1:0]          s_data_o,
    input  logic [N_SLAVES*XLEN-1:0] s_data_i,
    input  logic [N_SLAVES-1:0]      s_ready_i
);

    generate
        if (N_SLAVES < 1 || N_SLAVES > MAX_SLAVES || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("aquila_dbus_router: N_SLAVES must be 1..8 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    dbus_state_t         state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;

    logic                w_hit;
    logic [N_SLAVES-1:0] w_onehot;
    logic [SEL_W-1:0]    w_index;
    logic                w_ext;
    logic [N_SLAVES-1:0] w_sel_oh;
    logic [XLEN-1:0]     w_sel_data;
    logic                w_stale_hit;

    aquila_region_decoder #(
        .XLEN        (XLEN),
        .N_SLAVES    (N_SLAVES),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK),
        .REGION_EXT  (REGION_EXT)
    ) u_decoder (
        .addr_i   (p_addr_i),
        .hit_o    (w_hit),
        .onehot_o (w_onehot),
        .index_o  (w_index),
        .ext_o    (w_ext)
    );

    assign p_addr_ext_o = w_ext;
    assign busy_o       = (state_q != ST_IDLE);

    // Select the latched slave's ready bit and read data.
    always_comb begin
        w_sel_oh   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                w_sel_oh[i] = 1'b1;
                w_sel_data  = s_data_i[i*XLEN +: XLEN];
            end
        end
    end

`ifdef AQUILA_DBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_SLAVES-1:0] stale_q, stale_d;

    assign w_stale_hit = |(w_onehot & stale_q);
`else
    assign w_stale_hit = 1'b0;
`endif

    // Next-state, slave request and core response generation.
    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        p_ready_o       = 1'b0;
        p_error_o       = 1'b0;
        p_data_o        = '0;
        s_strobe_o      = '0;
        s_rw_o          = '0;
        s_addr_o        = '0;
        s_byte_enable_o = '0;
        s_data_o        = '0;
`ifdef AQUILA_DBUS_TIMEOUT_EN
        cnt_d           = cnt_q;
        // Any completion from a timed-out slave retires its stale mark.
        stale_d         = stale_q & ~s_ready_i;
`endif
        case (state_q)
            ST_IDLE: begin
                if (p_strobe_i && !rst_i) begin
                    if (w_hit && !w_stale_hit) begin
                        s_strobe_o      = w_onehot;
                        s_rw_o          = p_rw_i ? w_onehot : '0;
                        s_addr_o        = p_addr_i;
                        s_byte_enable_o = p_byte_enable_i;
                        s_data_o        = p_data_i;
                        sel_d           = w_index;
                        state_d         = ST_WAIT;
`ifdef AQUILA_DBUS_TIMEOUT_EN
                        cnt_d           = '0;
`endif
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_WAIT: begin
                if (|(s_ready_i & w_sel_oh)) begin
                    p_ready_o = 1'b1;
                    p_data_o  = w_sel_data;
                    state_d   = ST_IDLE;
                end
`ifdef AQUILA_DBUS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    p_ready_o = 1'b1;
                    p_error_o = 1'b1;
                    stale_d   = stale_d | w_sel_oh;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_ERR: begin
                p_ready_o = 1'b1;
                p_error_o = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, selected-slave and timeout bookkeeping registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
`ifdef AQUILA_DBUS_TIMEOUT_EN
            cnt_q   <= '0;
            stale_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef AQUILA_DBUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
`endif
        end
    end

endmodule
`default_nettype wire
